// File: rtl/router_rx_pkg.sv
// Shared types and constants for the router packet reader.
// Holds the reader FSM state enum, field widths and header slice bounds.
package router_rx_pkg;

   localparam int LEN_W = 6;
   localparam int ADDR_W = 2;

   localparam int HDR_LEN_HI = 7;
   localparam int HDR_LEN_LO = 2;
   localparam int HDR_ADDR_HI = 1;
   localparam int HDR_ADDR_LO = 0;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_PAYLOAD,
      ST_PARITY,
      ST_DONE
   } rx_state_e;

endpackage

// File: rtl/router_rx_skid.sv
// Circular output buffer of DEPTH entries holding payload byte + last flag.
// Ports: i_push/i_data/i_last write, i_pop read, o_data/o_last/o_valid head, o_count occupancy.
module router_rx_skid #(
   parameter int DEPTH = 2,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_last,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic          o_last,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);

   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

   logic [8:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= {i_last, i_data};
            r_wr <= (r_wr == LAST_IDX) ? '0 : r_wr + 1'b1;
         end
         if (i_pop) r_rd <= (r_rd == LAST_IDX) ? '0 : r_rd + 1'b1;
         unique case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Head is masked when empty so idle outputs read as zero.
   assign o_valid = (r_cnt != '0);
   assign o_data  = o_valid ? r_mem[r_rd][7:0] : 8'h00;
   assign o_last  = o_valid ? r_mem[r_rd][8] : 1'b0;
   assign o_count = r_cnt;

endmodule

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO: parses header, streams payload, checks parity.
// Ports: FIFO side (empty, fifo_data, read_enb), stream (out_*), status (pkt_*). Macro: RX_PARITY_CHECK_EN.
module router_pkt_reader
   import router_rx_pkg::*;
#(
   parameter int SKID_DEPTH = 2,
   parameter int ADDR_MAX = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              empty,
   input  logic [7:0]        fifo_data,
   output logic              read_enb,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              pkt_done,
   output logic [ADDR_W-1:0] pkt_addr,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              pkt_err
);

   localparam int CW = $clog2(SKID_DEPTH + 1);

   rx_state_e         r_state;
   rx_state_e         w_next;
   logic              r_live;
   logic              r_issued;
   logic              r_rd_hdr;
   logic              r_rd_pay;
   logic              r_rd_par;
   logic [LEN_W-1:0]  r_req;
   logic [LEN_W-1:0]  r_rcv;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic              r_err;
   logic              w_pop;
   logic              w_credit_ok;
   logic              w_last;
   logic              w_par_bad;
   logic [CW-1:0]     w_cnt;
   logic [LEN_W-1:0]  w_hdr_len;
   logic [ADDR_W-1:0] w_hdr_addr;

   assign w_hdr_len  = fifo_data[HDR_LEN_HI:HDR_LEN_LO];
   assign w_hdr_addr = fifo_data[HDR_ADDR_HI:HDR_ADDR_LO];
   assign w_pop      = out_valid & out_ready;
   assign w_last     = ((r_rcv + 1'b1) == r_len);

   // A pop this cycle frees a slot before the read's data can land.
   always_comb begin
      w_credit_ok = (SKID_DEPTH - int'(w_cnt) - int'(r_rd_pay) + int'(w_pop)) >= 1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_HDR;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_HDR:
            if (r_rd_hdr) w_next = (w_hdr_len == '0) ? ST_PARITY : ST_PAYLOAD;
         ST_PAYLOAD:
            if (read_enb && r_req == LEN_W'(1)) w_next = ST_PARITY;
         ST_PARITY:
            if (r_rd_par) w_next = ST_DONE;
         ST_DONE:
            w_next = ST_HDR;
         default:
            w_next = ST_HDR;
      endcase
   end

   always_comb begin
      read_enb = 1'b0;
      pkt_done = 1'b0;
      unique case (r_state)
         ST_HDR:     read_enb = r_live && !empty && !r_issued;
         ST_PAYLOAD: read_enb = r_live && !empty && (r_req != '0) && w_credit_ok;
         ST_PARITY:  read_enb = r_live && !empty && !r_issued;
         ST_DONE:    pkt_done = 1'b1;
         default:    read_enb = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_live   <= 1'b0;
         r_issued <= 1'b0;
         r_rd_hdr <= 1'b0;
         r_rd_pay <= 1'b0;
         r_rd_par <= 1'b0;
         r_req    <= '0;
         r_rcv    <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_live   <= 1'b1;
         r_rd_hdr <= read_enb && (r_state == ST_HDR);
         r_rd_pay <= read_enb && (r_state == ST_PAYLOAD);
         r_rd_par <= read_enb && (r_state == ST_PARITY);
         if (r_rd_hdr || r_rd_par)
            r_issued <= 1'b0;
         else if (read_enb && r_state != ST_PAYLOAD)
            r_issued <= 1'b1;
         if (r_rd_hdr) begin
            r_addr <= w_hdr_addr;
            r_len  <= w_hdr_len;
            r_req  <= w_hdr_len;
            r_rcv  <= '0;
            r_err  <= int'(w_hdr_addr) > ADDR_MAX;
         end else if (read_enb && r_state == ST_PAYLOAD) begin
            r_req <= r_req - 1'b1;
         end
         if (r_rd_pay) r_rcv <= r_rcv + 1'b1;
         if (r_rd_par) r_err <= r_err | w_par_bad;
      end
   end

`ifdef RX_PARITY_CHECK_EN
   logic [7:0] r_par;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       r_par <= '0;
      else if (r_rd_hdr) r_par <= fifo_data;
      else if (r_rd_pay) r_par <= r_par ^ fifo_data;
   end

   assign w_par_bad = (fifo_data != r_par);
`else
   assign w_par_bad = 1'b0;
`endif

   router_rx_skid #(
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (r_rd_pay),
      .i_data  (fifo_data),
      .i_last  (w_last),
      .i_pop   (w_pop),
      .o_data  (out_data),
      .o_last  (out_last),
      .o_valid (out_valid),
      .o_count (w_cnt)
   );

   assign pkt_addr = r_addr;
   assign pkt_len  = r_len;
   assign pkt_err  = r_err;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Scoreboard bench for router_pkt_reader with a behavioural FIFO source.
// Expected beats/packets are queued at send time; a monitor pops and compares.
module tb_router_pkt_reader;

   logic       clk;
   logic       resetn;
   logic       empty;
   logic [7:0] fifo_data;
   logic       read_enb;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       pkt_done;
   logic [1:0] pkt_addr;
   logic [5:0] pkt_len;
   logic       pkt_err;

   typedef struct packed {
      logic       last;
      logic [7:0] d;
   } beat_t;

   typedef struct packed {
      logic [1:0] a;
      logic [5:0] l;
      logic       e;
   } pk_t;

`ifdef RX_PARITY_CHECK_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic [7:0] fq [$];
   beat_t      exp_q [$];
   pk_t        pk_q [$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_rd = 0;
   int acc_cnt = 0;
   int prev_acc = 0;
   bit in_pkt = 0;
   bit contig_chk = 0;
   bit tog_en = 0;
   bit stall_en = 0;
   bit stall = 0;

   router_pkt_reader #(
      .SKID_DEPTH (2),
      .ADDR_MAX   (2)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .empty     (empty),
      .fifo_data (fifo_data),
      .read_enb  (read_enb),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .pkt_done  (pkt_done),
      .pkt_addr  (pkt_addr),
      .pkt_len   (pkt_len),
      .pkt_err   (pkt_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // FIFO source: decide the pop mid-cycle, apply it at the edge.
   initial begin
      bit rd_pend;
      fifo_data = 8'h00;
      forever begin
         @(negedge clk);
         #2;
         rd_pend = resetn && read_enb && !empty && (fq.size() != 0);
         @(posedge clk);
         if (rd_pend) fifo_data <= fq.pop_front();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         empty = stall || (fq.size() == 0);
      end
   end

   initial begin
      int tc = 0;
      int sc = 0;
      forever begin
         @(negedge clk);
         if (tog_en) begin
            tc++;
            if (tc == 3) begin
               out_ready = ~out_ready;
               tc = 0;
            end
         end
         if (stall_en) begin
            sc++;
            if (sc == 2) begin
               stall = ~stall;
               sc = 0;
            end
         end
      end
   end

   initial begin
      beat_t b;
      pk_t   p;
      forever begin
         @(negedge clk);
         #3;
         if (resetn) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_byte", int'(out_data), -1);
               end else begin
                  b = exp_q.pop_front();
                  chk("out_data", int'(out_data), int'(b.d));
                  chk("out_last", int'(out_last), int'(b.last));
               end
               if (contig_chk && in_pkt) chk("contig", cyc - prev_acc, 1);
               prev_acc = cyc;
               in_pkt = !out_last;
               acc_cnt++;
            end
            if (pkt_done) begin
               if (pk_q.size() == 0) begin
                  chk("extra_done", 1, 0);
               end else begin
                  p = pk_q.pop_front();
                  chk("pkt_addr", int'(pkt_addr), int'(p.a));
                  chk("pkt_len", int'(pkt_len), int'(p.l));
                  chk("pkt_err", int'(pkt_err), int'(p.e));
                  chk("done_lat", cyc - last_rd, 2);
               end
            end
            if (read_enb && !empty) last_rd = cyc;
         end
      end
   end

   task automatic send_pkt(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] seed, input bit flip);
      logic [7:0] h;
      logic [7:0] par;
      logic [7:0] b;
      h = {l, a};
      par = h;
      fq.push_back(h);
      for (int i = 0; i < int'(l); i++) begin
         b = seed + 8'(i) * 8'h11;
         par = par ^ b;
         fq.push_back(b);
         exp_q.push_back(beat_t'{last: (i == int'(l) - 1), d: b});
      end
      fq.push_back(flip ? ~par : par);
      pk_q.push_back(pk_t'{a: a, l: l, e: (a > 2'd2) || (flip && PEN)});
   endtask

   task automatic drain(input string nm, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || pk_q.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk(nm, int'(exp_q.size() + pk_q.size()), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_read_enb"}, int'(read_enb), 0);
      chk({tag, "_out_data"}, int'(out_data), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_last"}, int'(out_last), 0);
      chk({tag, "_pkt_done"}, int'(pkt_done), 0);
      chk({tag, "_pkt_addr"}, int'(pkt_addr), 0);
      chk({tag, "_pkt_len"}, int'(pkt_len), 0);
      chk({tag, "_pkt_err"}, int'(pkt_err), 0);
   endtask

   initial begin
      int k;
      int start;
      resetn = 1'b0;
      empty = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk_zero("rst");
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      contig_chk = 1'b1;
      send_pkt(2'd1, 6'd3, 8'h11, 1'b0);
      drain("drain_single", 100);
      contig_chk = 1'b0;

      send_pkt(2'd1, 6'd3, 8'h11, 1'b1);
      drain("drain_badpar", 100);

      send_pkt(2'd2, 6'd0, 8'h00, 1'b0);
      drain("drain_len0", 100);
      send_pkt(2'd3, 6'd0, 8'h00, 1'b0);
      drain("drain_addr3", 100);

      tog_en = 1'b1;
      send_pkt(2'd0, 6'd63, 8'h05, 1'b0);
      drain("drain_long", 2000);
      tog_en = 1'b0;
      out_ready = 1'b1;

      stall_en = 1'b1;
      send_pkt(2'd2, 6'd5, 8'h21, 1'b0);
      send_pkt(2'd1, 6'd4, 8'h37, 1'b1);
      drain("drain_stall", 500);
      stall_en = 1'b0;
      stall = 1'b0;
      send_pkt(2'd0, 6'd2, 8'h50, 1'b0);
      send_pkt(2'd3, 6'd6, 8'h62, 1'b0);
      drain("drain_b2b", 500);

      start = acc_cnt;
      send_pkt(2'd1, 6'd20, 8'h09, 1'b0);
      k = 0;
      while (acc_cnt < start + 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("mid_wait_timeout", int'(acc_cnt >= start + 3), 1);
      @(negedge clk);
      #6;
      resetn = 1'b0;
      #1;
      chk_zero("midrst");
      fq.delete();
      exp_q.delete();
      pk_q.delete();
      in_pkt = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      send_pkt(2'd2, 6'd3, 8'h70, 1'b0);
      drain("drain_post_rst", 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
